ntt_butterfly_unit: RTL and testbench

Data-path counterpart to the NTT address generator. It consumes the two coefficients read from coefficient RAM for one butterfly (lower then upper) plus a twiddle factor. It computes a Cooley-Tukey butterfly modulo Q with a bit-serial modular reducer, then returns the two results in write order (lower then upper). It sits between the RAM read/write ports and the address/sequencing logic, and uses valid/ready handshakes on both sides.

---
 rtl/ntt_butterfly_unit.sv | 116 +++++++++++
 tb/tb_ntt_butterfly_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_unit.sv
// rtl/ntt_butterfly_unit.sv - Cooley-Tukey butterfly mod Q with a bit-serial modular reducer
// Reads a then (b, w); writes a+b*w then a-b*w (mod Q), lower address first.
module ntt_butterfly_unit #(
  parameter int DATA_W = 16,
  parameter int Q      = 12289,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdValid,
  output logic              rdReady,
  input  logic [DATA_W-1:0] rdData,
  input  logic [DATA_W-1:0] twiddle,
  output logic              wrValid,
  input  logic              wrReady,
  output logic [DATA_W-1:0] wrData,
  output logic              wrSel,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, WAIT_B, MUL, RED, FIN, OUT_A, OUT_B
  } state_t;

  localparam logic [DATA_W:0]  QX       = (DATA_W+1)'(Q);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2*DATA_W-1);

  state_t state, nextState;

  logic [DATA_W-1:0]   a, b, w, r, bPrime;
  logic [2*DATA_W-1:0] p;
  logic [CNT_W-1:0]    cnt;

  logic              pBit;
  logic [DATA_W:0]   rAcc, rRed, sumAT, addRes, subRes;

  // One reduction step: shift in the next product bit (MSB first) and fold back below Q.
  always_comb begin
    pBit   = p[LAST_BIT - cnt];
    rAcc   = {r, 1'b0} + (DATA_W+1)'(pBit);
    rRed   = (rAcc >= QX) ? rAcc - QX : rAcc;
    sumAT  = {1'b0, a} + {1'b0, r};
    addRes = (sumAT >= QX) ? sumAT - QX : sumAT;
    subRes = (a >= r) ? {1'b0, a} - {1'b0, r} : {1'b0, a} + QX - {1'b0, r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (rdValid) nextState = WAIT_B;
      WAIT_B:  if (rdValid) nextState = MUL;
      MUL:     nextState = RED;
      RED:     if (cnt == LAST_BIT) nextState = FIN;
      FIN:     nextState = OUT_A;
      OUT_A:   if (wrReady) nextState = OUT_B;
      OUT_B:   if (wrReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a       <= '0;
      b       <= '0;
      w       <= '0;
      p       <= '0;
      r       <= '0;
      cnt     <= '0;
      bPrime  <= '0;
      wrData  <= '0;
      wrValid <= 1'b0;
      wrSel   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rdValid) a <= rdData;
        WAIT_B: if (rdValid) begin
          b <= rdData;
          w <= twiddle;
        end
        MUL: begin
          p   <= b * w;
          r   <= '0;
          cnt <= '0;
        end
        RED: begin
          r   <= DATA_W'(rRed);
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          wrData  <= DATA_W'(addRes);
          bPrime  <= DATA_W'(subRes);
          wrValid <= 1'b1;
          wrSel   <= 1'b0;
        end
        OUT_A: if (wrReady) begin
          wrData <= bPrime;
          wrSel  <= 1'b1;
        end
        OUT_B: if (wrReady) begin
          wrValid <= 1'b0;
          wrSel   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rdReady = (state == IDLE) || (state == WAIT_B);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// tb/tb_ntt_butterfly_unit.sv - self-checking bench for ntt_butterfly_unit
// Expected results come from plain modular arithmetic on the inputs.
module tb_ntt_butterfly_unit;

  localparam int DATA_W = 16;
  localparam int Q      = 12289;
  localparam int LIMIT  = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdValid = 1'b0;
  logic              rdReady;
  logic [DATA_W-1:0] rdData = '0;
  logic [DATA_W-1:0] twiddle = '0;
  logic              wrValid;
  logic              wrReady = 1'b1;
  logic [DATA_W-1:0] wrData;
  logic              wrSel;
  logic              busy;

  int tests  = 0;
  int failed = 0;
  int edgeCnt = 0;

  ntt_butterfly_unit #(.DATA_W(DATA_W), .Q(Q), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .twiddle(twiddle),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData), .wrSel(wrSel),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int w, output int ea, output int eb);
    int t;
    t  = (b * w) % Q;
    ea = (a + t) % Q;
    eb = (a - t + Q) % Q;
  endfunction

  task automatic pushWord(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] tw, input string tag);
    int n = 0;
    rdData = d; twiddle = tw; rdValid = 1'b1;
    while (!rdReady && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check({tag, " rdReady timeout"}, n, 0);
    @(posedge clk);
    #1 rdValid = 1'b0;
  endtask

  // Latency counts the b-accept edge as edge 1; total counts edges after it up to the OUT_B transfer.
  task automatic runBfly(input int a, input int b, input int w, input int stallA, input int stallB,
                         input bit noise, input string tag);
    int ea, eb, n, bEdge, lat;
    model(a, b, w, ea, eb);
    wrReady = 1'b1;
    pushWord(DATA_W'(a), '0, tag);
    pushWord(DATA_W'(b), DATA_W'(w), tag);
    bEdge = edgeCnt;
    wrReady = (stallA == 0);
    if (noise) begin
      repeat (5) @(negedge clk);
      rdValid = 1'b1; rdData = 16'd777; twiddle = 16'd777;
      repeat (3) @(negedge clk);
      check({tag, " rdReady in RED"}, rdReady, 0);
      rdValid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!wrValid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      check({tag, " wrValid timeout"}, n, 0);
      return;
    end
    lat = edgeCnt - bEdge + 1;
    check({tag, " latency"}, lat, 2*DATA_W+3);
    check({tag, " a' data"}, wrData, ea);
    check({tag, " a' sel"}, wrSel, 0);
    if (stallA > 0) rdValid = noise;
    for (int i = 0; i < stallA; i++) begin
      @(negedge clk);
      if (i == stallA - 1) begin
        check({tag, " stallA data"}, wrData, ea);
        check({tag, " stallA sel"}, wrSel, 0);
        check({tag, " stallA rdReady"}, rdReady, 0);
        check({tag, " stallA valid"}, wrValid, 1);
      end
    end
    rdValid = 1'b0;
    wrReady = 1'b1;
    @(posedge clk);
    #1 wrReady = (stallB == 0);
    @(negedge clk);
    check({tag, " b' data"}, wrData, eb);
    check({tag, " b' sel"}, wrSel, 1);
    check({tag, " b' valid"}, wrValid, 1);
    for (int i = 0; i < stallB; i++) begin
      @(negedge clk);
      if (i == stallB - 1) begin
        check({tag, " stallB data"}, wrData, eb);
        check({tag, " stallB sel"}, wrSel, 1);
      end
    end
    wrReady = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " total edges"}, edgeCnt - bEdge, 2*DATA_W + 4 + stallA + stallB);
    check({tag, " done valid"}, wrValid, 0);
    check({tag, " done rdReady"}, rdReady, 1);
    check({tag, " done busy"}, busy, 0);
  endtask

  initial begin
    // Reset held while rdValid toggles
    for (int i = 0; i < 4; i++) begin
      rdValid = i[0]; rdData = 16'd42;
      @(negedge clk);
      check("reset rdReady", rdReady, 1);
      check("reset wrValid", wrValid, 0);
      check("reset busy", busy, 0);
      check("reset wrData", wrData, 0);
    end
    rdValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post-reset busy", busy, 0);

    runBfly(5, 3, 2, 0, 0, 0, "basic");
    runBfly(12288, 12288, 12288, 0, 0, 0, "wrap max");
    runBfly(0, 1, 1, 0, 0, 0, "wrap zero");
    runBfly(1234, 4321, 999, 10, 5, 0, "backpressure");
    runBfly(7000, 8000, 9000, 3, 0, 1, "ignored rdValid");
    runBfly(11, 22, 33, 0, 0, 0, "after ignored");

    // Reset in the middle of RED discards the butterfly
    pushWord(16'd500, 16'd0, "midreset");
    pushWord(16'd600, 16'd700, "midreset");
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset wrValid", wrValid, 0);
    check("midreset rdReady", rdReady, 1);
    check("midreset busy", busy, 0);
    check("midreset wrData", wrData, 0);
    rdValid = 1'b1;
    @(negedge clk);
    rdValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    runBfly(100, 200, 300, 0, 0, 0, "fresh");

    for (int k = 0; k < 20; k++) begin
      runBfly($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
              $urandom_range(0, 3), $urandom_range(0, 3), 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
